change_dispenser: RTL and testbench

- Downstream consumer of the vending machine's change outputs: the one-cycle coin pulses for 1000/500/100/50 won that the control unit emits while paying out change.
- Queues each coin request in a small FIFO and drives one of four coin-hopper motors with a fixed-width pulse plus recovery gap.
- Tracks per-denomination coin inventory and a running total of won actually paid out.
- Sits between the vending datapath top level and the physical hoppers; it is the receiving end of the change-pulse interface.

---
 rtl/change_dispenser_pkg.sv | 31 +++
 rtl/change_dispenser_if.sv | 33 +++
 rtl/change_dispenser_coin_fifo.sv | 46 ++++
 rtl/change_dispenser.sv | 149 ++++++++++++++
 tb/tb_change_dispenser.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/change_dispenser_pkg.sv
// Shared kind codes, denomination values, FSM encoding and motor mapping
// for the change dispenser.
package change_pkg;

  localparam logic [1:0] KIND_1000 = 2'd0;
  localparam logic [1:0] KIND_500  = 2'd1;
  localparam logic [1:0] KIND_100  = 2'd2;
  localparam logic [1:0] KIND_50   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FIRE = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  function automatic logic [15:0] denomValue(input logic [1:0] kind);
    logic [15:0] value;
    case (kind)
      KIND_1000: value = 16'd1000;
      KIND_500:  value = 16'd500;
      KIND_100:  value = 16'd100;
      default:   value = 16'd50;
    endcase
    return value;
  endfunction

  function automatic logic [3:0] motorOneHot(input logic [1:0] kind);
    return 4'b0001 << kind;
  endfunction

endpackage

// File: rtl/change_dispenser_if.sv
// Change-pulse interface between the vending control unit (master) and
// the change dispenser (slave), including refill and status signals.
interface change_dispenser_if #(
  parameter int INV_W = 8
);
  logic             in1000Won;
  logic             in500Won;
  logic             in100Won;
  logic             in50Won;
  logic             inRefill;
  logic [1:0]       inRefillKind;
  logic [INV_W-1:0] inRefillCnt;
  logic [3:0]       motorEn;
  logic             busy;
  logic             fifoFull;
  logic             overflow;
  logic             errMulti;
  logic             shortage;
  logic [3:0]       coinEmpty;
  logic [15:0]      outPaid;

  modport master (
    output in1000Won, in500Won, in100Won, in50Won,
    output inRefill, inRefillKind, inRefillCnt,
    input  motorEn, busy, fifoFull, overflow, errMulti, shortage, coinEmpty, outPaid
  );

  modport slave (
    input  in1000Won, in500Won, in100Won, in50Won,
    input  inRefill, inRefillKind, inRefillCnt,
    output motorEn, busy, fifoFull, overflow, errMulti, shortage, coinEmpty, outPaid
  );
endinterface

// File: rtl/change_dispenser_coin_fifo.sv
// Small synchronous FIFO of 2-bit coin kind codes; a push while full is
// accepted only when a pop frees the head slot at the same edge.
module coin_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push_i,
  input  logic       pop_i,
  input  logic [1:0] din_i,
  output logic [1:0] dout_o,
  output logic       full_o,
  output logic       empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [1:0]  mem [DEPTH];
  logic [AW:0] wrPtr_q, wrPtr_d;
  logic [AW:0] rdPtr_q, rdPtr_d;
  logic        wrEn, rdEn;

  assign empty_o = (wrPtr_q == rdPtr_q);
  assign full_o  = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
  assign dout_o  = mem[rdPtr_q[AW-1:0]];

  always_comb begin
    wrEn    = push_i && (!full_o || pop_i);
    rdEn    = pop_i && !empty_o;
    wrPtr_d = wrEn ? wrPtr_q + (AW+1)'(1) : wrPtr_q;
    rdPtr_d = rdEn ? rdPtr_q + (AW+1)'(1) : rdPtr_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wrEn) mem[wrPtr_q[AW-1:0]] <= din_i;
  end
endmodule

// File: rtl/change_dispenser.sv
// Queues coin requests, pulses one hopper motor per coin with a recovery
// gap, and tracks per-denomination inventory plus total won paid out.
module change_dispenser
  import change_pkg::*;
#(
  parameter int FIFO_DEPTH   = 8,
  parameter int PULSE_CYCLES = 4,
  parameter int GAP_CYCLES   = 2,
  parameter int INV_W        = 8,
  parameter int INIT_COUNT   = 20
) (
  input  logic clk_i,
  input  logic rst_i,
  change_dispenser_if.slave bus
);
  localparam int PCW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
  localparam int GCW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int SW  = INV_W + 1;

  state_t           state_q, state_d;
  logic [PCW-1:0]   pulseCnt_q, pulseCnt_d;
  logic [GCW-1:0]   gapCnt_q, gapCnt_d;
  logic [1:0]       curKind_q, curKind_d;
  logic [3:0]       motor_q, motor_d;
  logic [15:0]      paid_q, paid_d;
  logic             shortage_q, shortage_d;
  logic             errMulti_q, overflow_q;
  logic [INV_W-1:0] inv_q [4];
  logic [INV_W-1:0] inv_d [4];
  logic [SW-1:0]    addCnt [4];
  logic [SW-1:0]    sum [4];

  logic [3:0] req;
  logic       anyReq, multiReq, popNow, dec;
  logic [1:0] reqKind, headKind;
  logic       fifoFull, fifoEmpty;

  // Bit index of req equals the kind code, so 1000 won has the highest priority.
  assign req      = {bus.in50Won, bus.in100Won, bus.in500Won, bus.in1000Won};
  assign anyReq   = |req;
  assign multiReq = (req & (req - 4'd1)) != 4'd0;

  always_comb begin
    reqKind = KIND_50;
    if (req[2]) reqKind = KIND_100;
    if (req[1]) reqKind = KIND_500;
    if (req[0]) reqKind = KIND_1000;
  end

  coin_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .push_i (anyReq),
    .pop_i  (popNow),
    .din_i  (reqKind),
    .dout_o (headKind),
    .full_o (fifoFull),
    .empty_o(fifoEmpty)
  );

  // The last gap cycle can pop directly so coins sit PULSE+GAP cycles apart.
  always_comb begin
    state_d    = state_q;
    pulseCnt_d = pulseCnt_q;
    gapCnt_d   = gapCnt_q;
    curKind_d  = curKind_q;
    motor_d    = motor_q;
    paid_d     = paid_q;
    shortage_d = 1'b0;
    dec        = 1'b0;
    popNow     = 1'b0;
    case (state_q)
      ST_FIRE: begin
        if (pulseCnt_q == '0) begin
          motor_d  = 4'b0000;
          dec      = 1'b1;
          paid_d   = paid_q + denomValue(curKind_q);
          state_d  = ST_GAP;
          gapCnt_d = GCW'(GAP_CYCLES - 1);
        end else begin
          pulseCnt_d = pulseCnt_q - PCW'(1);
        end
      end
      ST_GAP: begin
        if (gapCnt_q == '0) state_d = ST_IDLE;
        else                gapCnt_d = gapCnt_q - GCW'(1);
      end
      default: ;
    endcase
    if (((state_q == ST_IDLE) || ((state_q == ST_GAP) && (gapCnt_q == '0))) && !fifoEmpty) begin
      popNow = 1'b1;
      if (inv_q[headKind] != '0) begin
        state_d    = ST_FIRE;
        motor_d    = motorOneHot(headKind);
        curKind_d  = headKind;
        pulseCnt_d = PCW'(PULSE_CYCLES - 1);
      end else begin
        shortage_d = 1'b1;
        state_d    = ST_IDLE;
      end
    end
  end

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      addCnt[k] = (bus.inRefill && (bus.inRefillKind == 2'(k))) ? {1'b0, bus.inRefillCnt} : '0;
      sum[k]    = {1'b0, inv_q[k]} + addCnt[k] - (((dec && (curKind_q == 2'(k)))) ? SW'(1) : SW'(0));
      inv_d[k]  = sum[k][INV_W] ? '1 : sum[k][INV_W-1:0];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      pulseCnt_q <= '0;
      gapCnt_q   <= '0;
      curKind_q  <= KIND_1000;
      motor_q    <= 4'b0000;
      paid_q     <= 16'd0;
      shortage_q <= 1'b0;
      errMulti_q <= 1'b0;
      overflow_q <= 1'b0;
      for (int k = 0; k < 4; k++) inv_q[k] <= INV_W'(INIT_COUNT);
    end else begin
      state_q    <= state_d;
      pulseCnt_q <= pulseCnt_d;
      gapCnt_q   <= gapCnt_d;
      curKind_q  <= curKind_d;
      motor_q    <= motor_d;
      paid_q     <= paid_d;
      shortage_q <= shortage_d;
      errMulti_q <= multiReq;
      overflow_q <= overflow_q | (anyReq && fifoFull && !popNow);
      for (int k = 0; k < 4; k++) inv_q[k] <= inv_d[k];
    end
  end

  always_comb begin
    for (int k = 0; k < 4; k++) bus.coinEmpty[k] = (inv_q[k] == '0);
  end

  assign bus.motorEn  = motor_q;
  assign bus.busy     = (state_q != ST_IDLE) | ~fifoEmpty;
  assign bus.fifoFull = fifoFull;
  assign bus.overflow = overflow_q;
  assign bus.errMulti = errMulti_q;
  assign bus.shortage = shortage_q;
  assign bus.outPaid  = paid_q;
endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser: stimulus queues expected coins,
// a negedge monitor checks each motor pulse and shortage event in order.
module tb_change_dispenser;
  localparam int PULSE = 4;
  localparam int GAP   = 2;

  typedef struct packed {
    logic [1:0] kind;
    logic       shortage;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   testCount = 0;
  int   failCount = 0;
  exp_t sbQ [$];

  always #5 clk = ~clk;

  change_dispenser_if #(.INV_W(8)) cdIf ();

  change_dispenser #(
    .FIFO_DEPTH  (8),
    .PULSE_CYCLES(PULSE),
    .GAP_CYCLES  (GAP),
    .INV_W       (8),
    .INIT_COUNT  (20)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (cdIf)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Drives one cycle of inputs starting at a negedge, then clears them.
  task automatic applyStimulus(input logic [3:0] req, input logic refill,
                               input logic [1:0] kind, input logic [7:0] cnt);
    cdIf.in1000Won    = req[0];
    cdIf.in500Won     = req[1];
    cdIf.in100Won     = req[2];
    cdIf.in50Won      = req[3];
    cdIf.inRefill     = refill;
    cdIf.inRefillKind = kind;
    cdIf.inRefillCnt  = cnt;
    @(negedge clk);
    cdIf.in1000Won    = 1'b0;
    cdIf.in500Won     = 1'b0;
    cdIf.in100Won     = 1'b0;
    cdIf.in50Won      = 1'b0;
    cdIf.inRefill     = 1'b0;
    cdIf.inRefillKind = 2'd0;
    cdIf.inRefillCnt  = 8'd0;
  endtask

  task automatic expectCoin(input logic [1:0] kind);
    sbQ.push_back('{kind: kind, shortage: 1'b0});
  endtask

  task automatic expectShortage(input logic [1:0] kind);
    sbQ.push_back('{kind: kind, shortage: 1'b1});
  endtask

  task automatic applyReset();
    rst = 1'b1;
    sbQ.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic waitIdle(input string name);
    int n = 0;
    while (cdIf.busy && n < 400) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, cdIf.busy, 1'b0);
    @(negedge clk);
    checkOutput({name, "Drained"}, sbQ.size(), 0);
  endtask

  logic [3:0] prevMotor;
  int         width, offCount;
  bit         seenPulse;
  exp_t       mon;

  // Each rising motor edge or shortage pulse consumes the oldest expectation.
  always @(negedge clk) begin
    if (rst) begin
      prevMotor = 4'b0000;
      width     = 0;
      offCount  = 0;
      seenPulse = 1'b0;
    end else begin
      if (cdIf.motorEn != 4'b0000 && prevMotor == 4'b0000) begin
        if (seenPulse) checkOutput("gapAtLeast2", offCount >= GAP, 1'b1);
        if (sbQ.size() == 0) begin
          testCount++;
          failCount++;
          $display("[TB] FAIL unexpectedPulse: got motor %b, expected no coin", cdIf.motorEn);
        end else begin
          mon = sbQ.pop_front();
          checkOutput("motorKind", cdIf.motorEn, mon.shortage ? 4'b0000 : (4'b0001 << mon.kind));
        end
        width = 1;
      end else if (cdIf.motorEn != 4'b0000) begin
        width++;
      end
      if (cdIf.motorEn == 4'b0000) begin
        if (prevMotor != 4'b0000) begin
          checkOutput("pulseWidth", width, PULSE);
          seenPulse = 1'b1;
          offCount  = 1;
        end else begin
          offCount++;
        end
      end
      if (cdIf.shortage) begin
        if (sbQ.size() == 0) begin
          testCount++;
          failCount++;
          $display("[TB] FAIL unexpectedShortage: got shortage 1, expected 0");
        end else begin
          mon = sbQ.pop_front();
          checkOutput("shortageExpected", mon.shortage, 1'b1);
        end
      end
      prevMotor = cdIf.motorEn;
    end
  end

  initial begin
    cdIf.in1000Won = 1'b0;  cdIf.in500Won = 1'b0;
    cdIf.in100Won  = 1'b0;  cdIf.in50Won  = 1'b0;
    cdIf.inRefill  = 1'b0;  cdIf.inRefillKind = 2'd0;  cdIf.inRefillCnt = 8'd0;
    @(negedge clk);
    applyReset();
    checkOutput("rstMotor", cdIf.motorEn, 4'b0000);
    checkOutput("rstPaid", cdIf.outPaid, 16'd0);
    checkOutput("rstCoinEmpty", cdIf.coinEmpty, 4'b0000);
    checkOutput("rstBusy", cdIf.busy, 1'b0);
    checkOutput("rstFull", cdIf.fifoFull, 1'b0);
    checkOutput("rstOverflow", cdIf.overflow, 1'b0);
    checkOutput("rstErrMulti", cdIf.errMulti, 1'b0);
    checkOutput("rstShortage", cdIf.shortage, 1'b0);

    // Single 500 won coin: motor one edge after the request, idle after 4+2.
    expectCoin(2'd1);
    applyStimulus(4'b0010, 1'b0, 2'd0, 8'd0);
    checkOutput("t1MotorBefore", cdIf.motorEn, 4'b0000);
    checkOutput("t1BusyQueued", cdIf.busy, 1'b1);
    @(negedge clk);
    checkOutput("t1MotorOn", cdIf.motorEn, 4'b0010);
    repeat (5) @(negedge clk);
    checkOutput("t1BusyInGap", cdIf.busy, 1'b1);
    @(negedge clk);
    checkOutput("t1BusyLow", cdIf.busy, 1'b0);
    checkOutput("t1Paid", cdIf.outPaid, 16'd500);

    // Three denominations back to back, dispensed in arrival order.
    expectCoin(2'd0); expectCoin(2'd2); expectCoin(2'd3);
    applyStimulus(4'b0001, 1'b0, 2'd0, 8'd0);
    applyStimulus(4'b0100, 1'b0, 2'd0, 8'd0);
    applyStimulus(4'b1000, 1'b0, 2'd0, 8'd0);
    waitIdle("t2Idle");
    checkOutput("t2Paid", cdIf.outPaid, 16'd1650);

    // 1000 and 50 together: only 1000 queued, ERR_MULTI for one cycle.
    expectCoin(2'd0);
    applyStimulus(4'b1001, 1'b0, 2'd0, 8'd0);
    checkOutput("t3ErrMulti", cdIf.errMulti, 1'b1);
    @(negedge clk);
    checkOutput("t3ErrMultiClear", cdIf.errMulti, 1'b0);
    waitIdle("t3Idle");
    checkOutput("t3Paid", cdIf.outPaid, 16'd2650);

    // Reset during the third FIRE cycle aborts the coin.
    expectCoin(2'd0);
    applyStimulus(4'b0001, 1'b0, 2'd0, 8'd0);
    @(negedge clk);
    checkOutput("t4MotorOn", cdIf.motorEn, 4'b0001);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("t4MotorAbort", cdIf.motorEn, 4'b0000);
    checkOutput("t4PaidAbort", cdIf.outPaid, 16'd0);
    applyReset();
    checkOutput("t4CoinEmpty", cdIf.coinEmpty, 4'b0000);

    // Drain all 20 coins of 1000 won, then the 21st is a shortage.
    for (int i = 0; i < 20; i++) begin
      expectCoin(2'd0);
      applyStimulus(4'b0001, 1'b0, 2'd0, 8'd0);
      waitIdle("t5Drain");
    end
    checkOutput("t5Paid", cdIf.outPaid, 16'd20000);
    checkOutput("t5Empty1000", cdIf.coinEmpty, 4'b0001);
    expectShortage(2'd0);
    applyStimulus(4'b0001, 1'b0, 2'd0, 8'd0);
    @(negedge clk);
    checkOutput("t5Shortage", cdIf.shortage, 1'b1);
    checkOutput("t5NoMotor", cdIf.motorEn, 4'b0000);
    waitIdle("t5ShortIdle");
    checkOutput("t5PaidUnchanged", cdIf.outPaid, 16'd20000);
    applyStimulus(4'b0000, 1'b1, 2'd0, 8'd5);
    checkOutput("t5Refilled", cdIf.coinEmpty, 4'b0000);
    expectCoin(2'd0);
    applyStimulus(4'b0001, 1'b0, 2'd0, 8'd0);
    waitIdle("t5AfterRefill");
    checkOutput("t5PaidRefill", cdIf.outPaid, 16'd21000);

    // One 1000 firing, then ten 50s: nine fit (8 slots + one early pop).
    expectCoin(2'd0);
    applyStimulus(4'b0001, 1'b0, 2'd0, 8'd0);
    for (int i = 0; i < 10; i++) begin
      if (i < 9) expectCoin(2'd3);
      applyStimulus(4'b1000, 1'b0, 2'd0, 8'd0);
      if (i == 8) begin
        checkOutput("t6FullAt9", cdIf.fifoFull, 1'b1);
        checkOutput("t6NoOverflowYet", cdIf.overflow, 1'b0);
      end
    end
    checkOutput("t6Overflow", cdIf.overflow, 1'b1);
    waitIdle("t6Idle");
    checkOutput("t6Paid", cdIf.outPaid, 16'd22450);
    checkOutput("t6OverflowSticky", cdIf.overflow, 1'b1);

    // 66 coins of 1000 won wrap OUT_PAID: 66000 mod 65536 = 464.
    applyReset();
    applyStimulus(4'b0000, 1'b1, 2'd0, 8'd25);
    applyStimulus(4'b0000, 1'b1, 2'd0, 8'd25);
    for (int i = 0; i < 66; i++) begin
      expectCoin(2'd0);
      applyStimulus(4'b0001, 1'b0, 2'd0, 8'd0);
      waitIdle("t7Coin");
    end
    checkOutput("t7PaidWrap", cdIf.outPaid, 16'd464);
    checkOutput("t7NotEmpty", cdIf.coinEmpty, 4'b0000);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end
endmodule
